// File: rtl/usb_rx_ll_gen.sv
// usb_rx_ll_gen: low-level USB receiver (bit clock recovery, NRZI decode, bit-stuff, SYNC, EOP, bus reset).
// Latency: P/2+1 clocks from a line edge to the first ll_valid (P = OVS, or 8*OVS in low-speed); +2 with filter.
// Backpressure: none; ll_valid is a one-cycle strobe every P clocks while ll_active.
// Optional: define USB_RX_LL_GEN_GLITCH_FILT_EN to add a 2-clock agreement filter on dp/dn.
module usb_rx_ll_gen #(
  parameter int OVS          = 4,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_MIN  = 2,
  parameter int SYNC_ALT_MIN = 5,
  parameter int RST_CYC      = 60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phy_rx_dp,
  input  logic       phy_rx_dn,
  input  logic       phy_rx_chg,
  input  logic       cfg_ls,
  output logic [1:0] ll_sym,
  output logic       ll_bit,
  output logic       ll_valid,
  output logic       ll_eop,
  output logic       ll_sync,
  output logic       ll_bs_skip,
  output logic       ll_bs_err,
  output logic       ll_bus_rst,
  output logic       ll_active
);

  localparam int CW = $clog2(8 * OVS);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int EW = $clog2(EOP_SE0_MIN + 1);
  localparam int SW = $clog2(SYNC_ALT_MIN + 1);
  localparam int RW = $clog2(RST_CYC + 1);

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic line_dp;
  logic line_dn;
  logic line_chg;

`ifdef USB_RX_LL_GEN_GLITCH_FILT_EN
  logic [1:0] raw_q;
  logic [1:0] filt;
  logic [1:0] filt_q;
  logic       filt_ok;
  logic       unused_phy_rx_chg;

  assign unused_phy_rx_chg = phy_rx_chg;

  // Accept a new line value only once it has been seen on two consecutive clocks;
  // the first accepted value after reset primes filt_q so it does not look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q   <= 2'b00;
      filt    <= 2'b00;
      filt_q  <= 2'b00;
      filt_ok <= 1'b0;
    end else begin
      raw_q  <= {phy_rx_dp, phy_rx_dn};
      filt_q <= filt;
      if ({phy_rx_dp, phy_rx_dn} == raw_q) begin
        filt    <= {phy_rx_dp, phy_rx_dn};
        filt_ok <= 1'b1;
        if (!filt_ok) filt_q <= {phy_rx_dp, phy_rx_dn};
      end
    end
  end

  assign line_dp  = filt[1];
  assign line_dn  = filt[0];
  assign line_chg = (filt != filt_q);
`else
  assign line_dp  = phy_rx_dp;
  assign line_dn  = phy_rx_dn;
  assign line_chg = phy_rx_chg;
`endif

  // Low-speed idle is dp=0/dn=1, so swapping the pair makes J/K speed-independent.
  logic [1:0] sym;
  assign sym = cfg_ls ? {line_dn, line_dp} : {line_dp, line_dn};

  logic          cfg_ls_q;
  logic          cfg_chg;
  logic [CW-1:0] per_m1;
  logic [CW-1:0] half_m1;
  logic [CW-1:0] cnt;
  logic          strobe;
  logic          deact;

  assign cfg_chg = cfg_ls ^ cfg_ls_q;
  assign per_m1  = cfg_ls ? CW'(8 * OVS - 1) : CW'(OVS - 1);
  assign half_m1 = cfg_ls ? CW'(4 * OVS - 1) : CW'(OVS / 2 - 1);
  assign strobe  = ll_active && (cnt == '0) && !cfg_chg;
  assign deact   = ll_valid && (ll_eop || ll_bs_err);

  // Activity tracking and bit-phase counter; any edge re-centres the sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ls_q  <= 1'b0;
      ll_active <= 1'b0;
      cnt       <= '0;
    end else begin
      cfg_ls_q <= cfg_ls;
      if (cfg_chg || deact) ll_active <= 1'b0;
      else if (line_chg)    ll_active <= 1'b1;
      if (!ll_active || line_chg) cnt <= half_m1;
      else if (cnt == '0)         cnt <= per_m1;
      else                        cnt <= cnt - CW'(1);
    end
  end

  // Per-sample decode, evaluated against the state left by the previous sample.
  logic [1:0]    prev_sym;
  logic [OW-1:0] ones;
  logic [EW-1:0] eop_cnt;
  logic [SW-1:0] sync_cnt;
  logic          is_jk;
  logic          nrzi;
  logic          stuff_full;
  logic          eop_hit;
  logic          sync_hit;
  logic [SW-1:0] sync_inc;

  assign is_jk      = (sym == SYM_J) || (sym == SYM_K);
  assign nrzi       = is_jk && (sym == prev_sym);
  assign stuff_full = (ones == OW'(STUFF_LEN));
  assign eop_hit    = (sym == SYM_J) && (eop_cnt == EW'(EOP_SE0_MIN));
  assign sync_hit   = (sym == SYM_K) && (prev_sym == SYM_K) && (sync_cnt >= SW'(SYNC_ALT_MIN));
  assign sync_inc   = (sync_cnt >= SW'(SYNC_ALT_MIN)) ? sync_cnt : sync_cnt + SW'(1);

  // Decode history: ones run, SE0 run and J/K alternation run; wiped at packet end or speed change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sym <= SYM_SE0;
      ones     <= '0;
      eop_cnt  <= '0;
      sync_cnt <= '0;
    end else if (cfg_chg || deact) begin
      prev_sym <= SYM_SE0;
      ones     <= '0;
      eop_cnt  <= '0;
      sync_cnt <= '0;
    end else if (strobe) begin
      prev_sym <= sym;
      if (nrzi) ones <= stuff_full ? ones : ones + OW'(1);
      else      ones <= '0;
      if (sym == SYM_SE0)
        eop_cnt <= (eop_cnt == EW'(EOP_SE0_MIN)) ? eop_cnt : eop_cnt + EW'(1);
      else
        eop_cnt <= '0;
      if (!is_jk)
        sync_cnt <= '0;
      else if (sym == SYM_K) begin
        if (prev_sym == SYM_K)
          sync_cnt <= sync_hit ? SW'(0) : SW'(1);
        else if ((prev_sym == SYM_J) && (sync_cnt != '0))
          sync_cnt <= sync_inc;
        else
          sync_cnt <= SW'(1);
      end else begin
        if ((prev_sym == SYM_K) && (sync_cnt != '0))
          sync_cnt <= sync_inc;
        else
          sync_cnt <= '0;
      end
    end
  end

  // Registered sample outputs; flags are pulses aligned with ll_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ll_valid   <= 1'b0;
      ll_sym     <= 2'b00;
      ll_bit     <= 1'b0;
      ll_eop     <= 1'b0;
      ll_sync    <= 1'b0;
      ll_bs_skip <= 1'b0;
      ll_bs_err  <= 1'b0;
    end else begin
      ll_valid   <= strobe;
      ll_eop     <= strobe && eop_hit;
      ll_sync    <= strobe && sync_hit;
      ll_bs_skip <= strobe && stuff_full && is_jk && !nrzi;
      ll_bs_err  <= strobe && stuff_full && nrzi;
      if (strobe) begin
        ll_sym <= sym;
        ll_bit <= nrzi;
      end
    end
  end

  // Bus reset watches the unfiltered pins on every clock, regardless of packet tracking.
  logic          raw_se0;
  logic [RW-1:0] rst_cnt;
  logic [RW-1:0] rst_cnt_nxt;

  assign raw_se0 = !phy_rx_dp && !phy_rx_dn;

  // Saturating SE0 run length.
  always_comb begin
    rst_cnt_nxt = '0;
    if (raw_se0)
      rst_cnt_nxt = (rst_cnt == RW'(RST_CYC)) ? rst_cnt : rst_cnt + RW'(1);
  end

  // Register the run length and its terminal flag together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt    <= '0;
      ll_bus_rst <= 1'b0;
    end else begin
      rst_cnt    <= rst_cnt_nxt;
      ll_bus_rst <= (rst_cnt_nxt == RW'(RST_CYC));
    end
  end

endmodule

// File: tb/tb_usb_rx_ll_gen.sv
`timescale 1ns/1ps
module tb_usb_rx_ll_gen;

  localparam int OVS = 4;
`ifdef USB_RX_LL_GEN_GLITCH_FILT_EN
  localparam int LAT = 2;
  localparam bit GF  = 1'b1;
`else
  localparam int LAT = 0;
  localparam bit GF  = 1'b0;
`endif
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       dp     = 1'b1;
  logic       dn     = 1'b0;
  logic       chg    = 1'b0;
  logic       cfg_ls = 1'b0;
  logic [1:0] ll_sym;
  logic       ll_bit, ll_valid, ll_eop, ll_sync, ll_bs_skip, ll_bs_err, ll_bus_rst, ll_active;

  usb_rx_ll_gen #(
    .OVS(OVS), .STUFF_LEN(6), .EOP_SE0_MIN(2), .SYNC_ALT_MIN(5), .RST_CYC(60000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .phy_rx_dp(dp), .phy_rx_dn(dn), .phy_rx_chg(chg), .cfg_ls(cfg_ls),
    .ll_sym(ll_sym), .ll_bit(ll_bit), .ll_valid(ll_valid), .ll_eop(ll_eop), .ll_sync(ll_sync),
    .ll_bs_skip(ll_bs_skip), .ll_bs_err(ll_bs_err), .ll_bus_rst(ll_bus_rst), .ll_active(ll_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  sym;
    logic        b;
    logic        eop;
    logic        sync;
    logic        skip;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  bit   mon_en    = 1'b1;
  bit   chk_inact = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one symbol for a full bit period and queue the sample it should produce.
  task automatic send(input logic [1:0] s, input logic b, input logic eop, input logic sync,
                      input logic skip, input logic err, input bit glitch = 1'b0);
    int         p;
    logic [1:0] pins;
    exp_t       e;
    p     = cfg_ls ? 8 * OVS : OVS;
    pins  = cfg_ls ? {s[0], s[1]} : s;
    e.sym = s; e.b = b; e.eop = eop; e.sync = sync; e.skip = skip; e.err = err;
    e.cyc = 32'(cyc + p / 2 + 1 + LAT);
    q.push_back(e);
    chg = ({dp, dn} != pins);
    {dp, dn} = pins;
    tick();
    chg = 1'b0;
    for (int i = 1; i < p; i++) begin
      if (glitch && i == 2)      dp = ~pins[1];
      else if (glitch && i == 3) dp = pins[1];
      tick();
    end
  endtask

  task automatic drain();
    repeat (40) tick();
    chk("queue_drained", 32'(q.size()), 0);
  endtask

  // Scoreboard: every DUT strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (chk_inact) begin
        chk("active_clears_after_eop_err", 32'(ll_active), 0);
        chk_inact = 1'b0;
      end
      if (ll_valid) begin
        if (q.size() == 0) chk("unexpected_valid_queue_size", 32'(q.size()), 1);
        else begin
          e = q.pop_front();
          chk("valid_cycle", 32'(cyc), e.cyc);
          chk("ll_sym", 32'(ll_sym), 32'(e.sym));
          chk("ll_bit", 32'(ll_bit), 32'(e.b));
          chk("flags_eop_sync_skip_err", 32'({ll_eop, ll_sync, ll_bs_skip, ll_bs_err}),
              32'({e.eop, e.sync, e.skip, e.err}));
          chk("active_at_valid", 32'(ll_active), 1);
          chk_inact = e.eop | e.err;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({ll_sym, ll_bit, ll_valid, ll_eop, ll_sync, ll_bs_skip, ll_bs_err,
                              ll_bus_rst, ll_active}), 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // FS SYNC KJKJKJKK, then data bits 1,0
    send(K, 0, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0); send(K, 0, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0);
    send(K, 0, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0); send(K, 0, 0, 0, 0, 0); send(K, 1, 0, 1, 0, 0);
    send(K, 1, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0);
    // Six ones then a transition: stuff bit
    repeat (6) send(J, 1, 0, 0, 0, 0);
    send(K, 0, 0, 0, 1, 0);
    // Six ones then a seventh: stuff error, packet dropped
    repeat (6) send(K, 1, 0, 0, 0, 0);
    send(K, 1, 0, 0, 0, 1);
    drain();

    // Packet ending in SE0 SE0 J
    send(J, 0, 0, 0, 0, 0); send(K, 0, 0, 0, 0, 0);
    send(SE0, 0, 0, 0, 0, 0); send(SE0, 0, 0, 0, 0, 0); send(J, 0, 1, 0, 0, 0);
    drain();

    // New packet resyncs from idle; speed change mid-packet kills it
    send(K, 0, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0);
    repeat (LAT) tick();
    cfg_ls = 1'b1;
    tick();
    chk("cfg_toggle_inactive", 32'(ll_active), 0);
    drain();

    // Low-speed: idle J is dp=0/dn=1, SYNC and EOP as in full-speed
    send(J, 0, 0, 0, 0, 0);
    send(K, 0, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0); send(K, 0, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0);
    send(K, 0, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0); send(K, 0, 0, 0, 0, 0); send(K, 1, 0, 1, 0, 0);
    send(SE0, 0, 0, 0, 0, 0); send(SE0, 0, 0, 0, 0, 0); send(J, 0, 1, 0, 0, 0);
    drain();

    // Bus reset: long raw SE0, then a single J clock
    cfg_ls = 1'b0;
    repeat (4) tick();
    mon_en    = 1'b0;
    chk_inact = 1'b0;
    chg = 1'b1; dp = 1'b0; dn = 1'b0;
    tick();
    chg = 1'b0;
    repeat (59998) tick();
    chk("bus_rst_before_limit", 32'(ll_bus_rst), 0);
    tick();
    chk("bus_rst_at_limit", 32'(ll_bus_rst), 1);
    chg = 1'b1; dp = 1'b1; dn = 1'b0;
    tick();
    chg = 1'b0;
    chk("bus_rst_deassert", 32'(ll_bus_rst), 0);
    repeat (40) tick();
    chk("inactive_after_bus_rst_eop", 32'(ll_active), 0);
    mon_en = 1'b1;

    // Asynchronous reset in the middle of a SYNC
    send(K, 0, 0, 0, 0, 0); send(J, 0, 0, 0, 0, 0); send(K, 0, 0, 0, 0, 0);
    chg = 1'b1; dp = 1'b1; dn = 1'b0;
    tick();
    chg = 1'b0;
    repeat (OVS / 2 + LAT) tick();
    chk("valid_before_reset", 32'({ll_valid, ll_active}), 2'b11);
    rst_n = 1'b0;
    #1;
    chk("outputs_on_async_reset", 32'({ll_sym, ll_bit, ll_valid, ll_eop, ll_sync, ll_bs_skip,
                                       ll_bs_err, ll_bus_rst, ll_active}), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("no_activity_without_edge", 32'(ll_active), 0);
    send(K, 0, 0, 0, 0, 0);
    send(SE0, 0, 0, 0, 0, 0, GF);
    send(SE0, 0, 0, 0, 0, 0);
    send(J, 0, 1, 0, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
